// File: rtl/gpu_csr_pkg.sv
// Shared register-map constants for the GPU CSR bank.
// Word indices are in register units; the byte address is word * BYTES_PER_REG.
package gpu_csr_pkg;

   localparam int CSR_VERSION     = 0;
   localparam int CSR_IRQ_PENDING = 1;
   localparam int CSR_IRQ_ENABLE  = 2;
   localparam int CSR_DOORBELL    = 3;
   localparam int CSR_STAT_BASE   = 4;

   // The control block sits directly after the status words.
   function automatic int csr_ctrl_base(input int num_stat);
      return CSR_STAT_BASE + num_stat;
   endfunction

endpackage

// File: rtl/gpu_irq_ctrl.sv
// Edge-triggered interrupt block: rising-edge detect per source, W1C pending,
// RW enable and a registered irq_o.
module gpu_irq_ctrl #(
   parameter int IRQ_COUNT = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IRQ_COUNT-1:0] irq_src_i,
   input  logic [IRQ_COUNT-1:0] clr_i,
   input  logic                 en_wr_i,
   input  logic [IRQ_COUNT-1:0] wdata_i,
   input  logic [IRQ_COUNT-1:0] wmask_i,
   output logic [IRQ_COUNT-1:0] pending_o,
   output logic [IRQ_COUNT-1:0] enable_o,
   output logic                 irq_o
);

   logic [IRQ_COUNT-1:0] prev_q, pend_q, pend_d, enab_q, enab_d;
   logic                 irq_q;

   // The set term is applied after the clear term so a new edge beats a W1C.
   always_comb begin
      pend_d = (pend_q & ~clr_i) | (irq_src_i & ~prev_q);
      enab_d = en_wr_i ? ((enab_q & ~wmask_i) | (wdata_i & wmask_i)) : enab_q;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         prev_q <= '0;
         pend_q <= '0;
         enab_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         prev_q <= irq_src_i;
         pend_q <= pend_d;
         enab_q <= enab_d;
         irq_q  <= |(pend_q & enab_q);
      end
   end

   assign pending_o = pend_q;
   assign enable_o  = enab_q;
   assign irq_o     = irq_q;

endmodule

// File: rtl/gpu_csr_bank.sv
// Host-side CSR bank: version, IRQ block, doorbell, status and control words.
// Define GPU_CSR_SHADOW_EN to stage control writes in a shadow copy loaded by commit_i.
module gpu_csr_bank
   import gpu_csr_pkg::*;
#(
   parameter int          BYTES_PER_REG = 4,
   parameter int          NUM_STAT      = 2,
   parameter int          NUM_CTRL      = 2,
   parameter int          IRQ_COUNT     = 8,
   parameter logic [31:0] VERSION       = 32'h0001_0000,
   localparam int         W             = 8*BYTES_PER_REG,
   localparam int         ADDR_BITS     = $clog2((4+NUM_STAT+NUM_CTRL)*BYTES_PER_REG)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic [ADDR_BITS-1:0]     addr_i,
   input  logic [W-1:0]             din_i,
   input  logic [BYTES_PER_REG-1:0] we_i,
   output logic [W-1:0]             dout_o,
   input  logic [NUM_STAT*W-1:0]    status_i,
   output logic [NUM_CTRL*W-1:0]    control_o,
   input  logic [IRQ_COUNT-1:0]     irq_src_i,
   output logic                     irq_o,
   output logic [W-1:0]             doorbell_o,
   input  logic                     commit_i
);

   localparam int           OFFS      = $clog2(BYTES_PER_REG);
   localparam int           CTRL_BASE = csr_ctrl_base(NUM_STAT);
   localparam logic [W-1:0] VERSION_W = W'(VERSION);

   logic [ADDR_BITS-1:0]       word;
   logic [W-1:0]               bit_mask;
   logic [W-1:0]               dout_q, dout_d, doorbell_q, doorbell_d;
   logic [NUM_STAT-1:0][W-1:0] stat_q;
   logic [NUM_CTRL-1:0][W-1:0] ctrl_q, ctrl_host, ctrl_host_d;
   logic [IRQ_COUNT-1:0]       pending, enable, irq_clr;
   logic                       irq_en_wr;

   assign word = addr_i >> OFFS;

   always_comb begin
      bit_mask = '0;
      for (int b = 0; b < BYTES_PER_REG; b++) bit_mask[b*8 +: 8] = {8{we_i[b]}};
   end

   // Write decode; ctrl_host is whichever copy the host addresses.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      ctrl_host_d = ctrl_host;
      doorbell_d  = '0;
      irq_clr     = '0;
      irq_en_wr   = 1'b0;
      if (en_i) begin
         if (word == ADDR_BITS'(CSR_IRQ_PENDING)) irq_clr = din_i[IRQ_COUNT-1:0] & bit_mask[IRQ_COUNT-1:0];
         if (word == ADDR_BITS'(CSR_IRQ_ENABLE))  irq_en_wr = 1'b1;
         if (word == ADDR_BITS'(CSR_DOORBELL))    doorbell_d = din_i & bit_mask;
         for (int k = 0; k < NUM_CTRL; k++)
            if (word == ADDR_BITS'(CTRL_BASE + k))
               ctrl_host_d[k] = (ctrl_host[k] & ~bit_mask) | (din_i & bit_mask);
      end
   end

   // Reads see pre-write state, giving read-during-write the old value.
   always_comb begin
      dout_d = dout_q;
      if (en_i) begin
         dout_d = '0;
         if (word == ADDR_BITS'(CSR_VERSION))     dout_d = VERSION_W;
         if (word == ADDR_BITS'(CSR_IRQ_PENDING)) dout_d = W'(pending);
         if (word == ADDR_BITS'(CSR_IRQ_ENABLE))  dout_d = W'(enable);
         for (int k = 0; k < NUM_STAT; k++)
            if (word == ADDR_BITS'(CSR_STAT_BASE + k)) dout_d = stat_q[k];
         for (int k = 0; k < NUM_CTRL; k++)
            if (word == ADDR_BITS'(CTRL_BASE + k)) dout_d = ctrl_host[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dout_q     <= '0;
         doorbell_q <= '0;
      end else begin
         dout_q     <= dout_d;
         doorbell_q <= doorbell_d;
      end
   end

   // NOTE: stat_q is a plain pipeline copy of status_i, so it carries no reset.
   always_ff @(posedge clk_i) stat_q <= status_i;

`ifdef GPU_CSR_SHADOW_EN
   logic [NUM_CTRL-1:0][W-1:0] shadow_q;

   assign ctrl_host = shadow_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         ctrl_q   <= '0;
      end else begin
         shadow_q <= ctrl_host_d;
         if (commit_i) ctrl_q <= ctrl_host_d;
      end
   end
`else
   logic unused_commit;

   assign unused_commit = commit_i;
   assign ctrl_host     = ctrl_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) ctrl_q <= '0;
      else       ctrl_q <= ctrl_host_d;
   end
`endif

   gpu_irq_ctrl #(.IRQ_COUNT(IRQ_COUNT)) u_irq (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .irq_src_i (irq_src_i),
      .clr_i     (irq_clr),
      .en_wr_i   (irq_en_wr),
      .wdata_i   (din_i[IRQ_COUNT-1:0]),
      .wmask_i   (bit_mask[IRQ_COUNT-1:0]),
      .pending_o (pending),
      .enable_o  (enable),
      .irq_o     (irq_o)
   );

   assign dout_o     = dout_q;
   assign doorbell_o = doorbell_q;
   assign control_o  = ctrl_q;

endmodule

// File: tb/tb_gpu_csr_bank.sv
// Self-checking bench for gpu_csr_bank: directed register-map cases, then
// random traffic compared each cycle against a behavioural register-file model.
module tb_gpu_csr_bank;

   localparam int          BPR = 4;
   localparam int          NS  = 2;
   localparam int          NC  = 3;
   localparam int          IC  = 8;
   localparam int          W   = 32;
   localparam int          AB  = 6;
   localparam logic [31:0] VER = 32'h0001_0000;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          en_i = 1'b0;
   logic          commit_i = 1'b0;
   logic [AB-1:0] addr_i = '0;
   logic [W-1:0]  din_i = '0;
   logic [BPR-1:0] we_i = '0;
   logic [NS*W-1:0] status_i = '0;
   logic [IC-1:0] irq_src_i = '0;
   logic [W-1:0]  dout_o, doorbell_o;
   logic [NC*W-1:0] control_o;
   logic          irq_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpu_csr_bank #(
      .BYTES_PER_REG(BPR), .NUM_STAT(NS), .NUM_CTRL(NC), .IRQ_COUNT(IC), .VERSION(VER)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i), .din_i(din_i),
      .we_i(we_i), .dout_o(dout_o), .status_i(status_i), .control_o(control_o),
      .irq_src_i(irq_src_i), .irq_o(irq_o), .doorbell_o(doorbell_o), .commit_i(commit_i)
   );

   // Behavioural model: a register file indexed by word number.
   logic [W-1:0]  m_dout, m_door;
   logic [W-1:0]  m_stat [NS];
   logic [W-1:0]  m_host [NC];
   logic [W-1:0]  m_ctrl [NC];
   logic [IC-1:0] m_pend, m_en, m_prev;
   logic          m_irq;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                          input logic [BPR-1:0] be);
      logic [W-1:0] r;
      r = old_v;
      for (int b = 0; b < BPR; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   task automatic model_step();
      int           wd;
      logic [W-1:0] rd, mask, tmp;
      logic [IC-1:0] clr;
      if (rst_i) begin
         m_dout = '0; m_door = '0; m_pend = '0; m_en = '0; m_prev = '0; m_irq = 1'b0;
         for (int k = 0; k < NC; k++) begin m_host[k] = '0; m_ctrl[k] = '0; end
      end else begin
         wd   = int'(addr_i) / BPR;
         mask = merge('0, '1, we_i);
         rd   = '0;
         if (wd == 0)                         rd = VER;
         else if (wd == 1)                    rd = W'(m_pend);
         else if (wd == 2)                    rd = W'(m_en);
         else if (wd >= 4 && wd < 4 + NS)     rd = m_stat[wd-4];
         else if (wd >= 4 + NS && wd < 4 + NS + NC) rd = m_host[wd-4-NS];
         m_irq  = |(m_pend & m_en);
         clr    = '0;
         m_door = '0;
         if (en_i) begin
            m_dout = rd;
            if (wd == 1) clr = din_i[IC-1:0] & mask[IC-1:0];
            if (wd == 2) begin
               tmp  = merge(W'(m_en), din_i, we_i);
               m_en = tmp[IC-1:0];
            end
            if (wd == 3) m_door = din_i & mask;
            if (wd >= 4 + NS && wd < 4 + NS + NC)
               m_host[wd-4-NS] = merge(m_host[wd-4-NS], din_i, we_i);
         end
         m_pend = (m_pend & ~clr) | (irq_src_i & ~m_prev);
         m_prev = irq_src_i;
`ifdef GPU_CSR_SHADOW_EN
         if (commit_i) for (int k = 0; k < NC; k++) m_ctrl[k] = m_host[k];
`else
         for (int k = 0; k < NC; k++) m_ctrl[k] = m_host[k];
`endif
      end
      for (int k = 0; k < NS; k++) m_stat[k] = status_i[k*W +: W];
   endtask

   task automatic cycle();
      logic [NC*W-1:0] exp_ctrl;
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < NC; k++) exp_ctrl[k*W +: W] = m_ctrl[k];
      check("dout", dout_o, m_dout);
      check("irq", irq_o, m_irq);
      check("doorbell", doorbell_o, m_door);
      check("control", control_o, exp_ctrl);
   endtask

   task automatic drive(input logic en, input int wd, input logic [W-1:0] d, input logic [BPR-1:0] be);
      en_i = en; addr_i = AB'(wd * BPR); din_i = d; we_i = be;
   endtask

   initial begin
      drive(0, 0, '0, '0);
      rst_i = 1'b1;
      cycle(); cycle();
      rst_i = 1'b0;
      cycle();
      check("rst_dout", dout_o, 0);
      check("rst_irq", irq_o, 0);
      check("rst_ctrl", control_o, 0);
      check("rst_door", doorbell_o, 0);

      drive(1, 0, '0, '0); cycle();
      check("version", dout_o, 32'h0001_0000);

`ifdef GPU_CSR_SHADOW_EN
      drive(1, 4 + NS, 32'h55, 4'hF); cycle();
      check("shadow_hold", control_o[31:0], 0);
      drive(0, 0, '0, '0); commit_i = 1'b1; cycle(); commit_i = 1'b0;
      check("shadow_commit", control_o[31:0], 32'h55);
`endif

      drive(1, 4 + NS, 32'hDEAD_BEEF, 4'b0101); cycle();
`ifndef GPU_CSR_SHADOW_EN
      check("ctrl_wr", control_o[31:0], 32'h00AD_00EF);
`endif
      drive(1, 4 + NS, '0, '0); cycle();
      check("ctrl_rd", dout_o, 32'h00AD_00EF);

      // Interrupt: edge, irq_o, W1C, then edge and clear in the same cycle.
      drive(1, 2, 32'h08, 4'hF); cycle();
      drive(0, 0, '0, '0); irq_src_i = 8'h08; cycle();
      drive(1, 1, '0, '0); cycle();
      check("irq_pend", dout_o, 32'h08);
      check("irq_hi", irq_o, 1);
      drive(1, 1, 32'h08, 4'hF); cycle();
      drive(1, 1, '0, '0); cycle();
      check("irq_w1c", dout_o, 0);
      check("irq_lo", irq_o, 0);
      drive(0, 0, '0, '0); irq_src_i = '0; cycle();
      drive(1, 1, 32'h08, 4'hF); irq_src_i = 8'h08; cycle();
      drive(1, 1, '0, '0); cycle();
      check("irq_set_wins", dout_o, 32'h08);

      drive(1, 3, 32'h81, 4'b0001); cycle();
      check("door_pulse", doorbell_o, 32'h81);
      drive(1, 3, '0, '0); cycle();
      check("door_clear", doorbell_o, 0);
      check("door_rd", dout_o, 0);

      status_i = {32'h0000_1234, 32'hCAFE_0000};
      drive(0, 0, '0, '0); cycle();
      drive(1, 5, '0, '0); cycle();
      check("stat_rd", dout_o, 32'h1234);
      drive(1, 5, 32'hFFFF_FFFF, 4'hF); cycle();
      drive(1, 5, '0, '0); cycle();
      check("stat_ro", dout_o, 32'h1234);
      drive(1, 12, '0, '0); cycle();
      check("unmapped", dout_o, 0);
      drive(1, 4, '0, '0); cycle();
      drive(0, 1, '0, '0); cycle();
      check("en_low_hold", dout_o, 32'hCAFE_0000);

      // Reset during a write; source still high so it latches on exit.
      drive(1, 4 + NS + 1, 32'hFFFF_FFFF, 4'hF); rst_i = 1'b1; cycle(); rst_i = 1'b0;
      check("rst_mid_wr", control_o, 0);
      drive(1, 1, '0, '0); cycle();
      cycle();
      check("rst_exit_edge", dout_o, 32'h08);

      for (int i = 0; i < 600; i++) begin
         rst_i     = ($urandom_range(0, 63) == 0);
         en_i      = ($urandom_range(0, 3) != 0);
         addr_i    = AB'($urandom_range(0, 63));
         din_i     = $urandom;
         we_i      = BPR'($urandom);
         irq_src_i = IC'($urandom);
         status_i  = {$urandom, $urandom};
         commit_i  = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
